uart_rx_ovs: RTL and testbench

Parametrised oversampling UART receiver, the next generation of the UART serial-input block. It synchronises the asynchronous `rx` line, samples each bit with a 3-sample majority vote, and checks optional parity and 1–2 stop bits. Completed frames and their error flags are buffered in an internal FIFO and delivered on a valid/ready interface to the downstream consumer (register file or bus bridge).

---
 rtl/uart_rx_ovs.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - oversampling UART receiver with majority-vote sampling and frame FIFO
module uart_rx_ovs #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun,
    output logic                  busy
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam int M  = OVERSAMPLE / 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 3;

    if (TICK_DIV < 2) begin : g_bad_div
        $error("uart_rx_ovs: TICK_DIV must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || (OVERSAMPLE != 8 && OVERSAMPLE != 16)
        || (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2
        || (1 << AW) != FIFO_DEPTH) begin : g_bad_param
        $error("uart_rx_ovs: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q;
    logic                  rx_meta_q, rxs_q, rxs_prev_q;
    logic [2:0]            settle_q;
    logic [CW-1:0]         cnt_q;
    logic [SW-1:0]         sc_q;
    logic                  s0_q, s1_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IW-1:0]         bit_idx_q;
    logic                  stop_idx_q;
    logic                  par_bit_q, par_err_q, frame_err_q, stop1_zero_q, overrun_q;

    logic [AW:0]           wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [EW-1:0]         head, entry;
    logic                  tick, decide, bit_end, maj, last_stop, push, full, pop, wr_en;
    logic                  brk_new, fe_new, par_zero, stop1_zero;

    assign tick      = (state_q != S_IDLE) && (cnt_q == CW'(TICK_DIV - 1));
    assign decide    = tick && (sc_q == SW'(M + 1));
    assign bit_end   = tick && (sc_q == SW'(OVERSAMPLE - 1));
    assign maj       = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
    assign push      = decide && (state_q == S_STOP) && last_stop;

    // A break needs every sampled field, including the first stop bit, at 0.
    assign par_zero   = (PARITY_EN != 0) ? ~par_bit_q : 1'b1;
    assign stop1_zero = (STOP_BITS == 2) ? stop1_zero_q : ~maj;
    assign brk_new    = (shift_q == '0) && par_zero && stop1_zero;
    assign fe_new     = frame_err_q | ~maj | brk_new;
    assign entry      = {brk_new, fe_new, par_err_q, shift_q};

    assign rx_valid = (wr_ptr_q != rd_ptr_q);
    assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign pop      = rx_valid && rx_ready;
    assign wr_en    = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            settle_q     <= '0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sc_q         <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            par_bit_q    <= 1'b0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            stop1_zero_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            settle_q   <= {settle_q[1:0], 1'b1};
            overrun_q  <= push && full && !pop;
            if (state_q == S_IDLE) begin
                cnt_q <= '0;
                sc_q  <= '0;
                // settle_q keeps the reset value of the synchroniser from faking an edge.
                if (settle_q[2] && rxs_prev_q && !rxs_q) begin
                    state_q      <= S_START;
                    bit_idx_q    <= '0;
                    stop_idx_q   <= 1'b0;
                    par_bit_q    <= 1'b0;
                    par_err_q    <= 1'b0;
                    frame_err_q  <= 1'b0;
                    stop1_zero_q <= 1'b0;
                end
            end else begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    sc_q <= (sc_q == SW'(OVERSAMPLE - 1)) ? '0 : sc_q + 1'b1;
                    if (sc_q == SW'(M - 1)) s0_q <= rxs_q;
                    if (sc_q == SW'(M))     s1_q <= rxs_q;
                end
                case (state_q)
                    S_START: begin
                        if (decide && maj)  state_q <= S_IDLE;
                        else if (bit_end)   state_q <= S_DATA;
                    end
                    S_DATA: begin
                        if (decide) shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
                        if (bit_end) begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            if (bit_idx_q == IW'(DATA_WIDTH - 1))
                                state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        if (decide) begin
                            par_bit_q <= maj;
                            par_err_q <= (((^shift_q) ^ maj) != 1'(PARITY_ODD));
                        end
                        if (bit_end) state_q <= S_STOP;
                    end
                    S_STOP: begin
                        if (decide) begin
                            if (!maj) frame_err_q <= 1'b1;
                            if (!stop_idx_q) stop1_zero_q <= ~maj;
                            if (last_stop) state_q <= S_IDLE;
                        end
                        if (bit_end) stop_idx_q <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= entry;
    end

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_data    = rx_valid ? head[DATA_WIDTH-1:0] : '0;
    assign parity_err = rx_valid & head[DATA_WIDTH];
    assign frame_err  = rx_valid & head[DATA_WIDTH+1];
    assign break_det  = rx_valid & head[DATA_WIDTH+2];
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - randomized frame-level bench for uart_rx_ovs with queue model
module tb_uart_rx_ovs;
    localparam int CF = 1600000, BR = 10000, OV = 16, BIT = 160, DEPTH = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic rx_n = 1'b1, rdy_n = 1'b0, rx_p = 1'b1, rdy_p = 1'b0;
    logic [7:0] data_n, data_p;
    logic valid_n, pe_n, fe_n, brk_n, ovr_n, busy_n;
    logic valid_p, pe_p, fe_p, brk_p, ovr_p, busy_p;

    always #5 clk = ~clk;

    uart_rx_ovs #(.DATA_WIDTH(8), .CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OV),
                  .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_n (
        .clk(clk), .rst(rst), .rx(rx_n), .rx_data(data_n), .rx_valid(valid_n),
        .rx_ready(rdy_n), .parity_err(pe_n), .frame_err(fe_n), .break_det(brk_n),
        .overrun(ovr_n), .busy(busy_n));

    uart_rx_ovs #(.DATA_WIDTH(8), .CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OV),
                  .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_p (
        .clk(clk), .rst(rst), .rx(rx_p), .rx_data(data_p), .rx_valid(valid_p),
        .rx_ready(rdy_p), .parity_err(pe_p), .frame_err(fe_p), .break_det(brk_p),
        .overrun(ovr_p), .busy(busy_p));

    typedef struct packed {
        logic       brk;
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } ent_t;

    ent_t exp_q[$];
    ent_t got_e;
    int   n_tests = 0, n_fail = 0;
    int   ovr_seen = 0, ovr_exp = 0;
    bit   auto_chk = 0, rand_rdy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_n(input logic v, input int n);
        rx_n = v;
        wait_clk(n);
    endtask

    // Model: the entry a well-timed frame must yield, or an overrun if the buffer is full.
    task automatic send_n(input logic [7:0] d, input logic stop, input int noise_bit);
        ent_t e;
        drive_n(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == noise_bit) begin
                drive_n(d[i], 88);
                drive_n(1'b0, 10);
                drive_n(d[i], 62);
            end else begin
                drive_n(d[i], BIT);
            end
        end
        e.d   = d;
        e.pe  = 1'b0;
        e.brk = (d == 8'h00) && !stop;
        e.fe  = !stop;
        if (exp_q.size() == DEPTH) ovr_exp++;
        else exp_q.push_back(e);
        drive_n(stop, BIT);
    endtask

    task automatic send_p(input logic [7:0] d, input logic par);
        logic [10:0] bits;
        bits = {1'b1, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_p = bits[i];
            wait_clk(BIT);
        end
    endtask

    task automatic wait_valid_p(input string name);
        int k;
        k = 0;
        while (!valid_p && k < 3 * BIT) begin
            wait_clk(1);
            k++;
        end
        check(name, {31'd0, valid_p}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ovr_n) ovr_seen++;
            if (auto_chk && valid_n && rdy_n) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got data %0h with no entry expected", data_n);
                end else begin
                    got_e = exp_q.pop_front();
                    check("pop_entry", {21'd0, brk_n, fe_n, pe_n, data_n}, {21'd0, got_e});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rdy_n = 1'($urandom % 2);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       rs;
        wait_clk(5);
        check("rst_outputs", {data_n, valid_n, pe_n, fe_n, brk_n, ovr_n, busy_n}, 32'd0);
        rst = 1'b0;
        wait_clk(5);
        check("post_rst_idle", {valid_n, busy_n}, 32'd0);

        // Hand-checked single frame held at the head.
        send_n(8'hA5, 1'b1, -1);
        wait_clk(5);
        check("basic_valid", {31'd0, valid_n}, 32'd1);
        check("basic_data", {24'd0, data_n}, 32'hA5);
        check("basic_flags", {brk_n, fe_n, pe_n, busy_n}, 32'd0);
        void'(exp_q.pop_front());
        rdy_n = 1'b1;
        wait_clk(1);
        rdy_n = 1'b0;
        check("basic_popped", {31'd0, valid_n}, 32'd0);

        auto_chk = 1;
        rdy_n    = 1'b1;
        send_n(8'h3C, 1'b0, -1);
        drive_n(1'b1, 2 * BIT);
        check("ferr_drained", exp_q.size(), 32'd0);

        drive_n(1'b0, 40);
        drive_n(1'b1, 5);
        check("glitch_started", {31'd0, busy_n}, 32'd1);
        wait_clk(200);
        check("glitch_idle", {busy_n, valid_n}, 32'd0);

        // 12 bit times of low: one break entry only.
        exp_q.push_back('{brk: 1'b1, fe: 1'b1, pe: 1'b0, d: 8'h00});
        drive_n(1'b0, 12 * BIT);
        drive_n(1'b1, 2 * BIT);
        check("break_drained", exp_q.size(), 32'd0);
        check("break_idle", {busy_n, valid_n}, 32'd0);

        rand_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            rd = 8'($urandom);
            rs = ($urandom % 6) != 0;
            send_n(rd, rs, -1);
            if (!rs || ($urandom % 2)) drive_n(1'b1, 1 + $urandom % 2 * BIT);
        end
        drive_n(1'b1, 3 * BIT);
        rand_rdy = 0;
        rdy_n    = 1'b1;
        wait_clk(10);
        check("random_drained", exp_q.size(), 32'd0);

        rdy_n    = 1'b0;
        ovr_seen = 0;
        ovr_exp  = 0;
        for (int i = 1; i <= 5; i++) send_n(8'(i), 1'b1, -1);
        drive_n(1'b1, BIT);
        check("ovr_model", ovr_seen, ovr_exp);
        check("ovr_count", ovr_seen, 32'd1);
        check("ovr_head", {24'd0, data_n}, 32'h01);
        rdy_n = 1'b1;
        wait_clk(20);
        check("ovr_drained", exp_q.size(), 32'd0);

        rdy_n = 1'b0;
        send_n(8'h11, 1'b1, -1);
        send_n(8'h22, 1'b1, -1);
        check("rst_pre_valid", {31'd0, valid_n}, 32'd1);
        drive_n(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive_n(1'b1, BIT);
        drive_n(1'b0, 80);
        rst = 1'b1;
        #3;
        check("rst_mid_outputs", {data_n, valid_n, pe_n, fe_n, brk_n, ovr_n, busy_n}, 32'd0);
        exp_q.delete();
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3 * BIT);
        check("rst_no_false_start", {busy_n, valid_n}, 32'd0);
        drive_n(1'b1, 2 * BIT);

        rdy_n = 1'b1;
        send_n(8'hFF, 1'b1, 4);
        drive_n(1'b1, BIT);
        check("noise_drained", exp_q.size(), 32'd0);

        auto_chk = 0;
        send_p(8'h07, 1'b1);
        wait_valid_p("par_ok_valid");
        check("par_ok", {brk_p, fe_p, pe_p, data_p}, 32'h007);
        rdy_p = 1'b1;
        wait_clk(1);
        rdy_p = 1'b0;
        send_p(8'h07, 1'b0);
        wait_valid_p("par_bad_valid");
        check("par_bad", {brk_p, fe_p, pe_p, data_p}, 32'h107);
        rdy_p = 1'b1;
        wait_clk(1);
        rdy_p = 1'b0;
        check("par_popped", {31'd0, valid_p}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
